// File: rtl/dtmf_tone_sequencer_pkg.sv
// Shared definitions for the DTMF tone sequencer: FSM encoding, widths and
// the row/column half-period divisor tables (round(1e6 / (2*f)) at 1 MHz).
package dtmf_tone_sequencer_pkg;

   localparam int DIV_W = 10;
   localparam int TMR_W = 20;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TONE = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   // Index 0..3 = 697, 770, 852, 941 Hz
   localparam logic [DIV_W-1:0] ROW_DIV [4] = '{10'd717, 10'd649, 10'd587, 10'd531};
   // Index 0..3 = 1209, 1336, 1477, 1633 Hz
   localparam logic [DIV_W-1:0] COL_DIV [4] = '{10'd414, 10'd374, 10'd339, 10'd306};

endpackage

// File: rtl/dtmf_tone_sequencer_tone_divider.sv
// Square-wave generator: toggles its output every div enabled cycles and
// holds counter and output at 0 while disabled.
module tone_divider
   import dtmf_tone_sequencer_pkg::*;
(
   input  logic             clk_1m_in,
   input  logic             reset_in,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             tone_out
);

   logic [DIV_W-1:0] cnt_q;

   always_ff @(posedge clk_1m_in) begin
      if (reset_in || !en) begin
         cnt_q    <= '0;
         tone_out <= 1'b0;
      end else if (cnt_q == div - 10'd1) begin
         cnt_q    <= '0;
         tone_out <= ~tone_out;
      end else begin
         cnt_q    <= cnt_q + 10'd1;
      end
   end

endmodule

// File: rtl/dtmf_tone_sequencer.sv
// DTMF dialler: accepts one key at a time, plays a TONE_CYC-long dual-tone
// burst followed by a GAP_CYC-long silence, then pulses done_pulse.
module dtmf_tone_sequencer
   import dtmf_tone_sequencer_pkg::*;
#(
   parameter int TONE_CYC = 100000,
   parameter int GAP_CYC  = 50000
) (
   input  logic       clk_1m_in,
   input  logic       reset_in,
   input  logic [3:0] key_code,
   input  logic       key_valid,
   output logic       key_ready,
   input  logic       abort,
   output logic       busy,
   output logic       tone_active,
   output logic       row_tone_out,
   output logic       col_tone_out,
   output logic [1:0] tone_sum_out,
   output logic       done_pulse,
   output logic [1:0] dbg_state_o
);

   // Handshake: a key transfers on any rising edge where key_valid && key_ready;
   // key_ready is purely combinational and key_valid is never queued.

   localparam logic [TMR_W-1:0] TONE_LOAD = TMR_W'(TONE_CYC - 1);
   localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYC - 1);

   state_e           state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [DIV_W-1:0] row_div_q, row_div_d;
   logic [DIV_W-1:0] col_div_q, col_div_d;
   logic             busy_q, busy_d;
   logic             tone_active_q, tone_active_d;
   logic             done_q, done_d;
   logic             accept;
   logic             tone_en;

   always_ff @(posedge clk_1m_in) begin
      if (reset_in) begin
         state_q       <= ST_IDLE;
         timer_q       <= '0;
         row_div_q     <= '0;
         col_div_q     <= '0;
         busy_q        <= 1'b0;
         tone_active_q <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         row_div_q     <= row_div_d;
         col_div_q     <= col_div_d;
         busy_q        <= busy_d;
         tone_active_q <= tone_active_d;
         done_q        <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      row_div_d = row_div_q;
      col_div_d = col_div_q;
      done_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d   = ST_TONE;
               timer_d   = TONE_LOAD;
               row_div_d = ROW_DIV[key_code[3:2]];
               col_div_d = COL_DIV[key_code[1:0]];
            end
         end
         ST_TONE: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (timer_q == '0) begin
               state_d = ST_GAP;
               timer_d = GAP_LOAD;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         ST_GAP: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (timer_q == '0) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      key_ready     = (state_q == ST_IDLE) && !abort;
      accept        = key_valid && key_ready;
      busy_d        = (state_d != ST_IDLE);
      tone_active_d = (state_d == ST_TONE);
      // Dividers run only while staying in TONE, so they clear on the exit edge.
      tone_en       = (state_q == ST_TONE) && (state_d == ST_TONE);
   end

   tone_divider u_row_div (
      .clk_1m_in (clk_1m_in),
      .reset_in  (reset_in),
      .en        (tone_en),
      .div       (row_div_q),
      .tone_out  (row_tone_out)
   );

   tone_divider u_col_div (
      .clk_1m_in (clk_1m_in),
      .reset_in  (reset_in),
      .en        (tone_en),
      .div       (col_div_q),
      .tone_out  (col_tone_out)
   );

   assign busy         = busy_q;
   assign tone_active  = tone_active_q;
   assign done_pulse   = done_q;
   assign tone_sum_out = {1'b0, row_tone_out} + {1'b0, col_tone_out};
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_dtmf_tone_sequencer.sv
// Bench for dtmf_tone_sequencer: keypad vector table, directed corner
// sequences and random traffic, all checked against a phase/elapsed-time model.
`timescale 1ns/1ps
module tb_dtmf_tone_sequencer;

   localparam int TONE_CYC = 2000;
   localparam int GAP_CYC  = 500;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ready;
   logic       abort;
   logic       busy;
   logic       tone_active;
   logic       row_tone_out;
   logic       col_tone_out;
   logic [1:0] tone_sum_out;
   logic       done_pulse;
   logic [1:0] dbg_state;

   dtmf_tone_sequencer #(.TONE_CYC(TONE_CYC), .GAP_CYC(GAP_CYC)) dut (
      .clk_1m_in    (clk),
      .reset_in     (rst),
      .key_code     (key_code),
      .key_valid    (key_valid),
      .key_ready    (key_ready),
      .abort        (abort),
      .busy         (busy),
      .tone_active  (tone_active),
      .row_tone_out (row_tone_out),
      .col_tone_out (col_tone_out),
      .tone_sum_out (tone_sum_out),
      .done_pulse   (done_pulse),
      .dbg_state_o  (dbg_state)
   );

   always #500 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: phase 0 idle / 1 tone / 2 gap, cycles elapsed in phase.
   int m_phase = 0;
   int m_cnt   = 0;
   int m_rdiv  = 0;
   int m_cdiv  = 0;
   bit m_done  = 0;
   int row_tab [4];
   int col_tab [4];

   logic s_row, s_col, s_tone, s_busy, s_done;

   typedef struct {
      logic [3:0] key;
      int         row_first;
      int         col_first;
   } vec_t;
   vec_t vecs [6];

   function automatic void chk(string name, int act, int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic int half_period(real f);
      return $rtoi(1.0e6 / (2.0 * f) + 0.5);
   endfunction

   // Compare all outputs for the current cycle, then advance model and clock.
   task automatic tick();
      int e_row, e_col;
      @(negedge clk);
      e_row = (m_phase == 1) ? (m_cnt / m_rdiv) % 2 : 0;
      e_col = (m_phase == 1) ? (m_cnt / m_cdiv) % 2 : 0;
      chk("busy",        int'(busy),         int'(m_phase != 0));
      chk("tone_active", int'(tone_active),  int'(m_phase == 1));
      chk("row_tone",    int'(row_tone_out), e_row);
      chk("col_tone",    int'(col_tone_out), e_col);
      chk("tone_sum",    int'(tone_sum_out), e_row + e_col);
      chk("done_pulse",  int'(done_pulse),   int'(m_done));
      chk("key_ready",   int'(key_ready),    int'(m_phase == 0 && !abort));
      s_row  = row_tone_out;
      s_col  = col_tone_out;
      s_tone = tone_active;
      s_busy = busy;
      s_done = done_pulse;
      m_done = 0;
      if (rst) begin
         m_phase = 0; m_cnt = 0; m_rdiv = 0; m_cdiv = 0;
      end else begin
         case (m_phase)
            0: if (key_valid && !abort) begin
                  m_phase = 1; m_cnt = 0;
                  m_rdiv  = row_tab[key_code[3:2]];
                  m_cdiv  = col_tab[key_code[1:0]];
               end
            1: if (abort) m_phase = 0;
               else if (m_cnt == TONE_CYC - 1) begin m_phase = 2; m_cnt = 0; end
               else m_cnt++;
            default: if (abort) m_phase = 0;
               else if (m_cnt == GAP_CYC - 1) begin m_phase = 0; m_cnt = 0; m_done = 1; end
               else m_cnt++;
         endcase
      end
      @(posedge clk);
      #1;
   endtask

   task automatic dial(input logic [3:0] k);
      key_code  = k;
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
   endtask

   task automatic measure(input logic [3:0] k, output int rf, output int cf,
                          output int tl, output int bl, output int dc);
      rf = -1; cf = -1; tl = 0; bl = 0; dc = 0;
      dial(k);
      for (int n = 0; n < TONE_CYC + GAP_CYC + 100; n++) begin
         tick();
         if (rf < 0 && s_row) rf = n;
         if (cf < 0 && s_col) cf = n;
         if (s_tone) tl++;
         if (s_busy) bl++;
         if (s_done) dc++;
      end
   endtask

   initial begin
      int rf, cf, tl, bl, dc, dcyc, rf2, cf2, base;
      row_tab = '{half_period(697.0), half_period(770.0), half_period(852.0), half_period(941.0)};
      col_tab = '{half_period(1209.0), half_period(1336.0), half_period(1477.0), half_period(1633.0)};
      vecs[0] = '{4'h5, 649, 374};
      vecs[1] = '{4'hF, 531, 306};
      vecs[2] = '{4'h0, 717, 414};
      vecs[3] = '{4'h3, 717, 306};
      vecs[4] = '{4'hA, 587, 339};
      vecs[5] = '{4'h6, 649, 339};

      rst = 1'b1; key_valid = 1'b0; abort = 1'b0; key_code = 4'h0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      foreach (vecs[i]) begin
         measure(vecs[i].key, rf, cf, tl, bl, dc);
         chk("row_first_rise", rf, vecs[i].row_first);
         chk("col_first_rise", cf, vecs[i].col_first);
         chk("tone_len", tl, TONE_CYC);
         chk("busy_len", bl, TONE_CYC + GAP_CYC);
         chk("done_count", dc, 1);
      end

      // Back-to-back keys with key_valid held: second accepted on the done cycle.
      key_code = 4'hF; key_valid = 1'b1;
      tick();
      key_code = 4'h0;
      rf = -1; cf = -1; rf2 = -1; cf2 = -1; dcyc = -1; base = 0;
      for (int n = 0; n < 2 * (TONE_CYC + GAP_CYC) + 100; n++) begin
         tick();
         if (n == TONE_CYC + GAP_CYC + 1) key_valid = 1'b0;
         if (dcyc < 0) begin
            if (rf < 0 && s_row) rf = n;
            if (cf < 0 && s_col) cf = n;
            if (s_done) begin dcyc = n; base = n + 1; end
         end else begin
            if (rf2 < 0 && s_row) rf2 = n - base;
            if (cf2 < 0 && s_col) cf2 = n - base;
         end
      end
      chk("b2b_done_cycle", dcyc, TONE_CYC + GAP_CYC);
      chk("b2b_row1", rf, 531);
      chk("b2b_col1", cf, 306);
      chk("b2b_row2", rf2, 717);
      chk("b2b_col2", cf2, 414);

      // Key pulsed mid-tone is ignored.
      dial(4'h5);
      dc = 0;
      for (int n = 0; n < 2 * (TONE_CYC + GAP_CYC); n++) begin
         if (n == 100) begin key_code = 4'h3; key_valid = 1'b1; end
         tick();
         key_valid = 1'b0;
         if (s_done) dc++;
      end
      chk("ignored_key_done_count", dc, 1);

      // Abort mid-tone, then abort colliding with key_valid in idle.
      dial(4'hA);
      repeat (1000) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
      chk("abort_tone_active", int'(s_tone), 0);
      chk("abort_row", int'(s_row), 0);
      chk("abort_busy", int'(s_busy), 0);
      dc = 0;
      for (int n = 0; n < TONE_CYC + GAP_CYC; n++) begin
         tick();
         if (s_done) dc++;
      end
      chk("abort_no_done", dc, 0);
      key_code = 4'h5; key_valid = 1'b1; abort = 1'b1;
      tick();
      key_valid = 1'b0; abort = 1'b0;
      tick();
      chk("abort_blocks_accept", int'(s_busy), 0);

      // Reset in the middle of the gap.
      dial(4'h6);
      repeat (TONE_CYC + 200) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      chk("gap_reset_busy", int'(s_busy), 0);
      chk("gap_reset_done", int'(s_done), 0);
      dc = 0;
      for (int n = 0; n < GAP_CYC + 10; n++) begin
         tick();
         if (s_done) dc++;
      end
      chk("gap_reset_no_done", dc, 0);

      // Random traffic against the model.
      for (int n = 0; n < 15000; n++) begin
         rst       = ($urandom_range(0, 1499) == 0);
         abort     = ($urandom_range(0, 399) == 0);
         key_valid = ($urandom_range(0, 39) == 0);
         key_code  = 4'($urandom_range(0, 15));
         tick();
      end
      rst = 1'b0; abort = 1'b0; key_valid = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dtmf_tone_sequencer.md
DTMF_TONE_SEQUENCER -- requirements
Module: dtmf_tone_sequencer

Interface
REQ-001 Parameter TONE_CYC, default 100000: tone burst length in clk_1m_in cycles (100 ms at 1 MHz); legal range 1..2^20-1.
REQ-002 Parameter GAP_CYC, default 50000: silent inter-digit gap in cycles (50 ms); legal range 1..2^20-1.
REQ-003 clk_1m_in  input  1  1 MHz system clock, single clock domain.
REQ-004 reset_in  input  1  synchronous, active-high reset.
REQ-005 key_code  input  4  key to dial; row = key_code[3:2], column = key_code[1:0].
REQ-006 key_valid  input  1  key_code is valid this cycle.
REQ-007 key_ready  output  1  sequencer will accept a key this cycle.
REQ-008 abort  input  1  cancel the burst or gap in progress.
REQ-009 busy  output  1  high in TONE or GAP.
REQ-010 tone_active  output  1  high in TONE only.
REQ-011 row_tone_out  output  1  row-frequency square wave.
REQ-012 col_tone_out  output  1  column-frequency square wave.
REQ-013 tone_sum_out  output  2  row_tone_out + col_tone_out, unsigned, for a 2-bit DAC.
REQ-014 done_pulse  output  1  one-cycle pulse when a full tone+gap sequence completes.

Function
REQ-015 The FSM SHALL have states IDLE, TONE and GAP, all registered.
REQ-016 key_ready SHALL equal (state==IDLE) & ~abort, combinationally.
REQ-017 A key SHALL be accepted on a cycle where key_valid & key_ready; key_valid at any other time SHALL be ignored, with no queuing.
REQ-018 On accept, the block SHALL latch the row and column divisors, load the timer with TONE_CYC-1, and enter TONE on the next cycle.
REQ-019 Row divisors, indexed 0..3, SHALL be 717, 649, 587, 531 (697, 770, 852, 941 Hz), each equal to round(1e6/(2f)).
REQ-020 Column divisors, indexed 0..3, SHALL be 414, 374, 339, 306 (1209, 1336, 1477, 1633 Hz).
REQ-021 In TONE, the timer SHALL decrement once per cycle; when it reaches 0, the block SHALL load GAP_CYC-1 and enter GAP, so TONE lasts exactly TONE_CYC cycles.
REQ-022 In GAP, when the timer reaches 0, the block SHALL enter IDLE and assert done_pulse for exactly that transition cycle, so GAP lasts exactly GAP_CYC cycles.
REQ-023 abort in TONE or GAP SHALL force IDLE on the next edge, with no done_pulse; abort in IDLE SHALL have no effect except blocking acceptance (REQ-016).
REQ-024 Each tone generator's counter SHALL be 10 bits and be enabled only in TONE.
REQ-025 While a tone generator is disabled, its counter and output SHALL be 0.
REQ-026 While enabled, when counter == div-1 the counter SHALL clear and the output SHALL toggle; otherwise the counter SHALL increment.
REQ-027 Under REQ-026, the first toggle SHALL occur div cycles after TONE entry, giving an output period of 2*div cycles.
REQ-028 On leaving TONE for any reason, row_tone_out and col_tone_out SHALL be 0 on the next cycle.
REQ-029 The timer SHALL be 20 bits and count down only, with no wrap; the parameter range guarantees no overflow.
REQ-030 All outputs except key_ready SHALL be registered.

Reset
REQ-031 When reset_in is high at a clock edge, the block SHALL enter IDLE with timer=0 and divider counters=0.
REQ-032 After reset, busy, tone_active, row_tone_out, col_tone_out, tone_sum_out and done_pulse SHALL be 0, and latched divisors SHALL be 0.
REQ-033 Reset SHALL take priority over abort and key acceptance, including mid-TONE and mid-GAP.

Structure
REQ-034 A shared package SHALL hold the state encoding, the ROW_DIV/COL_DIV constant tables, and the widths DIV_W=10 and TMR_W=20.
REQ-035 A sub-module tone_divider (ports: clk_1m_in, reset_in, en, div[9:0], tone_out) SHALL be instantiated twice, once for row and once for column.

Verification (TONE_CYC=2000, GAP_CYC=500)
REQ-036 Reset: hold reset_in 3 cycles, then release -> all registered outputs 0 and key_ready=1.
REQ-037 Key 0x5 ('5', 770/1336 Hz) -> col_tone_out first rises 374 cycles and row_tone_out 649 cycles after TONE entry; tone_active high exactly 2000 cycles; busy high 2500 cycles; done_pulse 1 cycle; then key_ready=1.
REQ-038 Key 0xF then 0x0 back-to-back -> divisors 531/306, then 717/414; second key accepted only after done_pulse.
REQ-039 key_valid pulsed with key 0x3 at TONE cycle 100 -> ignored; the original divisors persist and no extra sequence runs.
REQ-040 abort at TONE cycle 1000 -> IDLE and tone outputs 0 next cycle, no done_pulse; abort simultaneous with key_valid in IDLE -> key not accepted.
REQ-041 reset_in asserted at GAP cycle 200 -> IDLE next cycle, all outputs 0, no done_pulse.
